// File: rtl/scope_pkg.sv
// Shared scope constants, colours and FSM state type for the
// trace write scheduler and its level decoder.
package scope_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int BAND_H     = 13;
    localparam int BAND_BASE  = 221;
    localparam int MID_FIRST  = 235;
    localparam int MID_LAST   = 240;
    localparam int MAX_LEVEL  = 17;

    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_TRACE = 12'h010;
    localparam logic [11:0] COL_MID   = 12'hFFF;
    localparam logic [11:0] COL_GRID  = 12'h333;

    typedef enum logic [1:0] {
        CLEAR,
        WAIT_SAMPLE,
        WRITE_COL,
        ADVANCE
    } state_t;

endpackage

// File: rtl/trace_level_decode.sv
// Maps a volts/tenths sample to the first row of its 13-row trace band.
// Purely combinational.
module trace_level_decode
    import scope_pkg::*;
(
    input  logic [7:0] sample_data,
    output logic [8:0] row_start
);

    logic [3:0] volts;
    logic [1:0] sub;
    logic [8:0] level;

    // Clamp volts to 5, bucket tenths into thirds, then place the band
    always_comb begin
        volts = (sample_data[7:4] > 4'd5) ? 4'd5 : sample_data[7:4];
        if (sample_data[3:0] <= 4'd3) begin
            sub = 2'd0;
        end else if (sample_data[3:0] <= 4'd6) begin
            sub = 2'd1;
        end else begin
            sub = 2'd2;
        end
        level     = 9'd3 * {5'd0, volts} + {7'd0, sub};
        row_start = 9'(BAND_BASE) - 9'(BAND_H) * level;
    end

endmodule

// File: rtl/trace_write_scheduler.sv
// Clears the frame, then draws one scope-trace column per sample.
// Optional background grid is enabled by defining TRACE_GRID_EN.
module trace_write_scheduler
    import scope_pkg::*;
(
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic [7:0]  sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [1:0]  mode,
    input  logic        v_blank,
    output logic        wr_en,
    output logic [8:0]  wr_row,
    output logic [9:0]  wr_col,
    output logic [11:0] wr_data,
    output logic        busy
);

    localparam logic [8:0] ROW_LAST  = 9'(V_ACTIVE - 1);
    localparam logic [9:0] COL_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [8:0] MID_LO    = 9'(MID_FIRST);
    localparam logic [8:0] MID_HI    = 9'(MID_LAST);
    localparam logic [8:0] BAND_SPAN = 9'(BAND_H - 1);

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  col_ptr;
    logic [8:0]  clr_row;
    logic [9:0]  clr_col;
    logic        clr_en;
    logic [7:0]  samp_q;
    logic [1:0]  mode_q;
    logic        hs;
    logic        clr_last;
    logic [7:0]  dec_in;
    logic [1:0]  mode_sel;
    logic [8:0]  row_start;
    logic [8:0]  row_nxt;
    logic [11:0] pix_nxt;
    logic        in_mid;
    logic        in_band;
    logic        trace_on;

    assign hs       = sample_valid && sample_ready;
    assign clr_last = (clr_row == ROW_LAST) && (clr_col == COL_LAST);

    // Row 0 is prepared at the handshake, before the sample is latched
    assign dec_in   = (state == WAIT_SAMPLE) ? sample_data : samp_q;
    assign mode_sel = (state == WAIT_SAMPLE) ? mode : mode_q;
    assign row_nxt  = (state == WAIT_SAMPLE) ? 9'd0 : wr_row + 9'd1;

    trace_level_decode u_decode (
        .sample_data (dec_in),
        .row_start   (row_start)
    );

`ifdef TRACE_GRID_EN
    logic on_grid;
    assign on_grid = (col_ptr[5:0] == 6'd0) || ((row_nxt % 9'd48) == 9'd0);
`endif

    // Colour of the next row to be presented: midline, trace, then background
    always_comb begin
        in_mid   = (row_nxt >= MID_LO) && (row_nxt <= MID_HI);
        in_band  = (row_nxt >= row_start) &&
                   (row_nxt <= row_start + BAND_SPAN);
        trace_on = (mode_sel == 2'd0) || (mode_sel == 2'd2);
        pix_nxt  = COL_BLACK;
        if (in_mid) begin
            pix_nxt = COL_MID;
        end else if (in_band && trace_on) begin
            pix_nxt = COL_TRACE;
`ifdef TRACE_GRID_EN
        end else if (on_grid) begin
            pix_nxt = COL_GRID;
`endif
        end
    end

    // State register
    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR:       if (clr_last) state_nxt = WAIT_SAMPLE;
            WAIT_SAMPLE: if (hs) state_nxt = WRITE_COL;
            WRITE_COL:   if (v_blank && wr_row == ROW_LAST) state_nxt = ADVANCE;
            ADVANCE:     state_nxt = WAIT_SAMPLE;
            default:     state_nxt = CLEAR;
        endcase
    end

    // Outputs decoded from state; column writes follow v_blank directly
    always_comb begin
        sample_ready = (state == WAIT_SAMPLE);
        busy         = (state != WAIT_SAMPLE);
        wr_en        = clr_en || ((state == WRITE_COL) && v_blank);
    end

    // Clear sweep, sample latch, row stepping and column pointer
    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            col_ptr <= '0;
            clr_row <= '0;
            clr_col <= '0;
            clr_en  <= 1'b0;
            samp_q  <= '0;
            mode_q  <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
        end else begin
            clr_en <= 1'b0;
            unique case (state)
                CLEAR: begin
                    clr_en  <= 1'b1;
                    wr_row  <= clr_row;
                    wr_col  <= clr_col;
                    wr_data <= COL_BLACK;
                    if (clr_col == COL_LAST) begin
                        clr_col <= '0;
                        clr_row <= (clr_row == ROW_LAST) ? 9'd0 : clr_row + 9'd1;
                    end else begin
                        clr_col <= clr_col + 10'd1;
                    end
                end
                WAIT_SAMPLE: begin
                    if (hs) begin
                        samp_q  <= sample_data;
                        mode_q  <= mode;
                        wr_row  <= row_nxt;
                        wr_col  <= col_ptr;
                        wr_data <= pix_nxt;
                    end
                end
                WRITE_COL: begin
                    if (v_blank && wr_row != ROW_LAST) begin
                        wr_row  <= row_nxt;
                        wr_data <= pix_nxt;
                    end
                end
                ADVANCE: begin
                    col_ptr <= (col_ptr == COL_LAST) ? 10'd0 : col_ptr + 10'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
